// File: rtl/leaf_pkt_pkg.sv
// Shared packet layout for the BFT leaf receive path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package leaf_pkt_pkg;

    localparam int PKT_W      = 49;
    localparam int VALID_BIT  = 48;
    localparam int PORT_HI    = 42;
    localparam int PORT_LO    = 39;
    localparam int PAYLOAD_HI = 31;
    localparam int PAYLOAD_W  = PAYLOAD_HI + 1;
    localparam int PORT_W     = PORT_HI - PORT_LO + 1;

    // Field order matches the wire format, MSB first.
    typedef struct packed {
        logic                 vld;        // [48]
        logic [4:0]           leaf_addr;  // [47:43], routing only, unused here
        logic [PORT_W-1:0]    port;       // [42:39]
        logic [6:0]           rsvd;       // [38:32]
        logic [PAYLOAD_W-1:0] payload;    // [31:0]
    } leaf_pkt_t;

endpackage

// File: rtl/leaf_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and push-while-full-with-pop.
// Latency: a push is visible at the head on the next cycle when the FIFO was empty.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module leaf_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             accept,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_pop;

    assign full   = (count == (AW + 1)'(DEPTH));
    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still take the push.
    assign accept = push && (!full || do_pop);
    // While empty, keep showing the last word that left so the output does not toggle.
    assign head   = empty ? last_q : mem[rd_ptr];

    // Storage array; no reset needed since empty entries are never presented.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers, occupancy and the held head value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({accept, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/leaf_stream_demux.sv
// Demultiplexes BFT leaf packets into per-port FWFT FIFOs feeding a page operator.
// Latency: 2 cycles from din to dout_valid into an empty FIFO once started.
// Backpressure: per-port valid/ready out; a packet hitting a full FIFO is dropped with a resend pulse.
module leaf_stream_demux
    import leaf_pkt_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ap_start,
    input  logic [PKT_W-1:0]            din_leaf_bft2interface,
    output logic [NUM_IN*PAYLOAD_W-1:0] dout_data,
    output logic [NUM_IN-1:0]           dout_valid,
    input  logic [NUM_IN-1:0]           dout_ready,
    output logic                        resend_req,
    output logic [PORT_W-1:0]           resend_port,
    output logic [NUM_IN-1:0]           overflow_sticky,
    output logic                        bad_port_sticky,
    output logic                        started
);

    localparam int AW = $clog2(FIFO_DEPTH);

    leaf_pkt_t         in_q;
    logic              port_ok;
    logic [NUM_IN-1:0] push_vec;
    logic [NUM_IN-1:0] acc_vec;
    logic [NUM_IN-1:0] drop_vec;
    logic [NUM_IN-1:0] pop_vec;
    logic [NUM_IN-1:0] unused_fifo_stat;
    logic              unused_fields;

    assign unused_fields = ^{in_q.leaf_addr, in_q.rsvd};

    // Stage 1: register the raw leaf packet every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q <= '0;
        end else begin
            in_q <= leaf_pkt_t'(din_leaf_bft2interface);
        end
    end

    assign port_ok  = in_q.vld && (int'(in_q.port) < NUM_IN);
    assign pop_vec  = dout_valid & dout_ready;
    assign drop_vec = push_vec & ~acc_vec;

    // Stage 2: one FIFO per operator input port.
    for (genvar p = 0; p < NUM_IN; p++) begin : gen_port
        logic [AW:0] cnt;
        logic        full;
        logic        empty;

        assign push_vec[p] = port_ok && (in_q.port == PORT_W'(p));

        leaf_sync_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (PAYLOAD_W)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push_vec[p]),
            .push_dat (in_q.payload),
            .pop      (pop_vec[p]),
            .accept   (acc_vec[p]),
            .head     (dout_data[p*PAYLOAD_W +: PAYLOAD_W]),
            .count    (cnt),
            .full     (full),
            .empty    (empty)
        );

        assign dout_valid[p]       = started && !empty;
        assign unused_fifo_stat[p] = ^{cnt, full};
    end

    // Start latch, drop reporting and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started         <= 1'b0;
            resend_req      <= 1'b0;
            resend_port     <= '0;
            overflow_sticky <= '0;
            bad_port_sticky <= 1'b0;
        end else begin
            started         <= started | ap_start;
            resend_req      <= |drop_vec;
            overflow_sticky <= overflow_sticky | drop_vec;
            if (|drop_vec) begin
                resend_port <= in_q.port;
            end
            if (in_q.vld && !port_ok) begin
                bad_port_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_leaf_stream_demux.sv
// Randomised and directed bench for leaf_stream_demux with a queue-based reference model.
// Latency: model tracks the 2-stage din-to-valid path and next-cycle drop reporting.
// Backpressure: dout_ready is driven per port, directed and random.
module tb_leaf_stream_demux;
    import leaf_pkt_pkg::*;

    localparam int NUM_IN = 4;
    localparam int DEPTH  = 16;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        ap_start;
    logic [PKT_W-1:0]            din;
    logic [NUM_IN*PAYLOAD_W-1:0] dout_data;
    logic [NUM_IN-1:0]           dout_valid;
    logic [NUM_IN-1:0]           dout_ready;
    logic                        resend_req;
    logic [3:0]                  resend_port;
    logic [NUM_IN-1:0]           overflow_sticky;
    logic                        bad_port_sticky;
    logic                        started;

    leaf_stream_demux #(.NUM_IN(NUM_IN), .FIFO_DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ap_start               (ap_start),
        .din_leaf_bft2interface (din),
        .dout_data              (dout_data),
        .dout_valid             (dout_valid),
        .dout_ready             (dout_ready),
        .resend_req             (resend_req),
        .resend_port            (resend_port),
        .overflow_sticky        (overflow_sticky),
        .bad_port_sticky        (bad_port_sticky),
        .started                (started)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int pop_cnt [NUM_IN];

    // Reference model state: stored payloads per port plus the flags they imply.
    logic [31:0]       mq [NUM_IN][$];
    logic              m_started;
    logic              m_resend;
    logic [3:0]        m_resend_port;
    logic [NUM_IN-1:0] m_ovf;
    logic              m_bad;
    leaf_pkt_t         stage2;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk_pkt(input logic v, input logic [3:0] port,
                                                input logic [31:0] pl);
        leaf_pkt_t k;
        k.vld       = v;
        k.leaf_addr = 5'($urandom);
        k.port      = port;
        k.rsvd      = 7'($urandom);
        k.payload   = pl;
        return k;
    endfunction

    // Monitor: compare DUT against the model, then advance the model one cycle.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_valid", 128'(dout_valid), 128'(0));
            chk("rst_data", 128'(dout_data), 128'(0));
            chk("rst_flags", 128'({resend_req, resend_port, overflow_sticky, bad_port_sticky, started}), 128'(0));
            for (int p = 0; p < NUM_IN; p++) mq[p].delete();
            m_started     = 1'b0;
            m_resend      = 1'b0;
            m_resend_port = '0;
            m_ovf         = '0;
            m_bad         = 1'b0;
            stage2        = '0;
        end else begin
            logic [NUM_IN-1:0] exp_v;
            for (int p = 0; p < NUM_IN; p++) begin
                exp_v[p] = m_started && (mq[p].size() > 0);
                if (dout_valid[p] && dout_ready[p]) pop_cnt[p]++;
            end
            chk("dout_valid", 128'(dout_valid), 128'(exp_v));
            for (int p = 0; p < NUM_IN; p++) begin
                if (exp_v[p]) chk($sformatf("dout_data[%0d]", p),
                                  128'(dout_data[p*32 +: 32]), 128'(mq[p][0]));
            end
            chk("resend_req", 128'(resend_req), 128'(m_resend));
            chk("resend_port", 128'(resend_port), 128'(m_resend_port));
            chk("overflow_sticky", 128'(overflow_sticky), 128'(m_ovf));
            chk("bad_port_sticky", 128'(bad_port_sticky), 128'(m_bad));
            chk("started", 128'(started), 128'(m_started));

            // Pops first: a slot freed this cycle may take this cycle's packet.
            for (int p = 0; p < NUM_IN; p++) begin
                if (exp_v[p] && dout_ready[p]) void'(mq[p].pop_front());
            end
            m_resend = 1'b0;
            if (stage2.vld) begin
                if (int'(stage2.port) >= NUM_IN) begin
                    m_bad = 1'b1;
                end else if (mq[stage2.port].size() < DEPTH) begin
                    mq[stage2.port].push_back(stage2.payload);
                end else begin
                    m_resend             = 1'b1;
                    m_resend_port        = stage2.port;
                    m_ovf[stage2.port]   = 1'b1;
                end
            end
            if (ap_start) m_started = 1'b1;
            stage2 = leaf_pkt_t'(din);
        end
    end

    // Drive one cycle of inputs; called at posedge+1.
    task automatic step(input logic [PKT_W-1:0] d, input logic [3:0] r, input logic a);
        din        = d;
        dout_ready = r;
        ap_start   = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [3:0] r);
        for (int i = 0; i < n; i++) step('0, r, 1'b0);
    endtask

    task automatic clear_pops();
        for (int p = 0; p < NUM_IN; p++) pop_cnt[p] = 0;
    endtask

    // Assert reset away from the clock edge and check outputs clear without a clock.
    task automatic do_reset();
        din      = '0;
        ap_start = 1'b0;
        reset    = 1'b0;
        #1;
        chk("async_rst_valid", 128'(dout_valid), 128'(0));
        chk("async_rst_data", 128'(dout_data), 128'(0));
        chk("async_rst_flags", 128'({resend_req, resend_port, overflow_sticky, bad_port_sticky, started}), 128'(0));
        @(posedge clk);
        #1;
        idle(1, 4'h0);
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        din        = '0;
        dout_ready = '0;
        ap_start   = 1'b0;
        clear_pops();
        #2;
        @(posedge clk);
        #1;
        do_reset();

        // Gating: packets stored before start are invisible, then drain in order.
        for (int i = 0; i < 5; i++) step(mk_pkt(1'b1, 4'd0, 32'hA0 + 32'(i)), 4'hF, 1'b0);
        idle(6, 4'hF);
        clear_pops();
        step('0, 4'hF, 1'b1);
        idle(10, 4'hF);
        chk("gating_drain", 128'(pop_cnt[0]), 128'(5));

        // Ordering on port 2.
        clear_pops();
        step(mk_pkt(1'b1, 4'd2, 32'h11), 4'hF, 1'b0);
        step(mk_pkt(1'b1, 4'd2, 32'h22), 4'hF, 1'b0);
        step(mk_pkt(1'b1, 4'd2, 32'h33), 4'hF, 1'b0);
        idle(8, 4'hF);
        chk("order_drain", 128'(pop_cnt[2]), 128'(3));

        // Overflow on port 1: the 17th packet is dropped.
        for (int i = 0; i < 17; i++) step(mk_pkt(1'b1, 4'd1, 32'h100 + 32'(i)), 4'b1101, 1'b0);
        idle(4, 4'b1101);
        clear_pops();
        idle(24, 4'hF);
        chk("ovf_drain", 128'(pop_cnt[1]), 128'(16));

        // Full port 3 with a pop in the same cycle as the push.
        for (int i = 0; i < 16; i++) step(mk_pkt(1'b1, 4'd3, 32'h300 + 32'(i)), 4'b0111, 1'b0);
        idle(2, 4'b0111);
        step(mk_pkt(1'b1, 4'd3, 32'h3FF), 4'b0111, 1'b0);
        clear_pops();
        step('0, 4'hF, 1'b0);
        idle(3, 4'b0111);
        idle(24, 4'hF);
        chk("fullpop_drain", 128'(pop_cnt[3]), 128'(17));

        // Out-of-range port.
        step(mk_pkt(1'b1, 4'd7, 32'hBAD), 4'hF, 1'b0);
        idle(4, 4'hF);

        // Mid-operation reset with port 0 holding 4 entries.
        for (int i = 0; i < 4; i++) step(mk_pkt(1'b1, 4'd0, 32'h500 + 32'(i)), 4'h0, 1'b0);
        idle(2, 4'h0);
        do_reset();
        step('0, 4'hF, 1'b1);
        idle(6, 4'hF);

        // Random traffic: scarce ready first to provoke drops, then plenty to drain.
        do_reset();
        idle(3, 4'h0);
        step('0, 4'h0, 1'b1);
        for (int c = 0; c < 1600; c++) begin
            logic [3:0] port;
            logic [3:0] rdy;
            port = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            rdy  = (c < 800) ? 4'($urandom & $urandom) : 4'($urandom | $urandom);
            step(mk_pkt(($urandom_range(0, 3) != 0), port, $urandom), rdy, ($urandom_range(0, 50) == 0));
        end
        idle(40, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
